// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: segment patterns, bit order and polarity shared by the display mux
package bcd_disp_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic LOW_ON  = 1'b0;
  localparam logic LOW_OFF = 1'b1;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd_disp_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low {g..a} pattern, dash for 10-15
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  // table lookup; anything above 9 is an invalid BCD code
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_disp_mux.sv
// bcd_disp_mux: double-buffered multiplexed 7-segment driver with zero blanking (optional DISP_DIMMING_EN)
module bcd_disp_mux
  import bcd_disp_pkg::*;
#(
  parameter int N           = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [N*4-1:0] bcd,
  input  logic [N-1:0]   dp,
  input  logic           lz_en,
`ifdef DISP_DIMMING_EN
  input  logic [3:0]     bright,
`endif
  output logic [N-1:0]   an,
  output logic [6:0]     seg,
  output logic           dp_n,
  output logic           frame_tick
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic [N*4-1:0] sh_bcd_q, disp_bcd_q;
  logic [N-1:0]   sh_dp_q, disp_dp_q, an_q, an_d, blank;
  logic [6:0]     seg_q, seg_d, dec_seg;
  logic [3:0]     digit;
  logic           pend_q, dpn_q, dpn_d, ft_q, slot_end, wrap, run, an_on;
`ifdef DISP_DIMMING_EN
  logic [3:0]     pwm_q;
  assign an_on = pwm_q <= bright;
`else
  assign an_on = 1'b1;
`endif
  assign slot_end = cnt_q == CW'(REFRESH_DIV - 1);
  assign wrap     = slot_end && idx_q == IW'(N - 1);
  assign digit    = disp_bcd_q[{idx_q, 2'b00} +: 4];
  // blanking runs from the top digit down until a nonzero/invalid digit or a dp stops it
  always_comb begin
    blank = '0;
    run = lz_en;
    for (int i = N - 1; i >= 1; i--) begin
      run = run && disp_bcd_q[4*i +: 4] == 4'd0 && !disp_dp_q[i];
      blank[i] = run;
    end
  end
  bcd_to_seg7 u_dec (.digit_i(digit), .seg_o(dec_seg));
  assign an_d  = an_on ? ~(N'(1) << idx_q) : '1;
  assign seg_d = blank[idx_q] ? SEG_BLANK : dec_seg;
  assign dpn_d = blank[idx_q] ? LOW_OFF : ~disp_dp_q[idx_q];
  // slot timing, double buffering and registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_bcd_q   <= '0;
      sh_dp_q    <= '0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      pend_q     <= 1'b0;
      ft_q       <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dpn_q      <= LOW_OFF;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + CW'(1);
      if (slot_end) idx_q <= idx_q == IW'(N - 1) ? '0 : idx_q + IW'(1);
      ft_q <= wrap;
      if (wrap) begin
        disp_bcd_q <= load ? bcd : pend_q ? sh_bcd_q : disp_bcd_q;
        disp_dp_q  <= load ? dp : pend_q ? sh_dp_q : disp_dp_q;
        pend_q     <= 1'b0;
      end else if (load) begin
        sh_bcd_q <= bcd;
        sh_dp_q  <= dp;
        pend_q   <= 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
    end
  end
`ifdef DISP_DIMMING_EN
  // free-running PWM phase for anode dimming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_q <= '0;
    else pwm_q <= pwm_q + 4'd1;
  end
`endif
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dpn_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_bcd_disp_mux.sv
// tb_bcd_disp_mux: directed and random checks of bcd_disp_mux against a cycle-count reference model
module tb_bcd_disp_mux;
  logic        clk = 1'b0, reset = 1'b1, load = 1'b0, lz_en = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dp = '0, an;
  logic [6:0]  seg;
  logic        dp_n, frame_tick;
  int          checks = 0, errors = 0;
  int          ec;
  logic [15:0] m_disp, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend, lz_v;
  logic [6:0]  segtab [16];

  bcd_disp_mux #(.N(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .bcd(bcd), .dp(dp), .lz_en(lz_en),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    ec = 0; m_disp = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_pend = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] b, input logic [3:0] d);
    int idx;
    logic blank, e_dpn, e_ft;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    @(negedge clk);
    load = ld; bcd = b; dp = d; lz_en = lz_v;
    idx = (ec / 4) % 4;
    blank = lz_v && idx != 0;
    for (int j = idx; j < 4; j++) if (m_disp[4*j +: 4] != 4'd0 || m_dp[j]) blank = 1'b0;
    e_seg = blank ? 7'h7F : segtab[m_disp[4*idx +: 4]];
    e_dpn = blank ? 1'b1 : !m_dp[idx];
    e_an  = ~(4'b0001 << idx);
    e_ft  = (ec % 16) == 15;
    if (e_ft) begin
      if (ld) begin m_disp = b; m_dp = d; end
      else if (m_pend) begin m_disp = m_sh; m_dp = m_shdp; end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh = b; m_shdp = d; m_pend = 1'b1;
    end
    ec++;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("an", 7'(an), 7'(e_an));
    chk("seg", seg, e_seg);
    chk("dp_n", 7'(dp_n), 7'(e_dpn));
    chk("frame_tick", 7'(frame_tick), 7'(e_ft));
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_an", 7'(an), 7'h0F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp_n", 7'(dp_n), 7'h01);
    chk("rst_ft", 7'(frame_tick), 7'h00);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_ft;
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 16'h0, 4'h0);
      seen = frame_tick;
    end
    chk("ft_seen", 7'(seen), 7'h01);
  endtask

  task automatic check_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpn);
    logic [6:0] s [4];
    logic [3:0] a;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      step(1'b0, 16'h0, 4'h0);
      a = ~(4'b0001 << d);
      chk("frame_an", 7'(an), 7'(a));
      chk("frame_seg", seg, s[d]);
      chk("frame_dp_n", 7'(dp_n), 7'(dpn[d]));
      repeat (3) step(1'b0, 16'h0, 4'h0);
    end
  endtask

  initial begin
    int n;
    logic [15:0] rb;
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) segtab[i] = 7'b0111111;
    lz_v = 1'b1;
    model_reset();
    do_reset();
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    step(1'b1, 16'h0123, 4'h0);
    wait_ft();
    check_frame(7'b0110000, 7'b0100100, 7'b1111001, 7'h7F, 4'hF);
    step(1'b1, 16'h00A5, 4'h0);
    wait_ft();
    check_frame(7'b0010010, 7'b0111111, 7'h7F, 7'h7F, 4'hF);
    lz_v = 1'b0;
    check_frame(7'b0010010, 7'b0111111, 7'b1000000, 7'b1000000, 4'hF);
    lz_v = 1'b1;
    step(1'b1, 16'h0012, 4'b0100);
    wait_ft();
    check_frame(7'b0100100, 7'b1111001, 7'b1000000, 7'h7F, 4'b1011);
    repeat (4) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h1111, 4'h0);
    wait_ft();
    check_frame(7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 4'hF);
    step(1'b1, 16'h2222, 4'h0);
    repeat (5) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h3456, 4'h0);
    wait_ft();
    check_frame(7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 4'hF);
    step(1'b0, 16'h0, 4'h0);
    while (ec % 16 != 15) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h7890, 4'b0001);
    chk("wrap_load_ft", 7'(frame_tick), 7'h01);
    check_frame(7'b1000000, 7'b0010000, 7'b0000000, 7'b1111000, 4'b1110);
    n = 0;
    repeat (64) begin
      step(1'b0, 16'h0, 4'h0);
      n += int'(frame_tick);
    end
    chk("ft_count", 7'(n), 7'd4);
    repeat (400) begin
      for (int k = 0; k < 4; k++) rb[4*k +: 4] = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lz_v = ~lz_v;
      step($urandom_range(0, 5) == 0, rb, $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'h0);
    end
    lz_v = 1'b1;
    step(1'b1, 16'h9876, 4'h0);
    repeat (21) step(1'b0, 16'h0, 4'h0);
    do_reset();
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_disp_mux.md
Name: bcd_disp_mux

Overview:
Downstream consumer of the sequential binary-to-BCD converter. Captures a packed N-digit BCD word on the converter's done_tick and drives a time-multiplexed, common-anode 7-segment display, one digit per refresh slot. Provides leading-zero blanking and invalid-digit indication. Updates are double-buffered so a new value never appears partway through a frame.

Parameters:
N, 4, number of BCD digits / display positions
REFRESH_DIV, 50000, clock cycles per digit slot (must be >= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
load  in  1  one-cycle strobe; connect to converter done_tick
bcd  in  N*4  packed digits, digit i = bcd[4i+3:4i], digit 0 least significant
dp  in  N  decimal point request per digit, captured with load
lz_en  in  1  leading-zero blanking enable (level, sampled continuously)
an  out  N  anode enables, active-low, one-hot-low when lit
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point segment, active-low
frame_tick  out  1  one-cycle pulse at frame boundary

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset values: an all 1, seg 7'h7F, dp_n 1, frame_tick 0. Slot counter, digit index, shadow register, display register and pending flag all clear to 0.
- Shadow register: on load=1, capture bcd and dp and set pending=1. Repeated loads within a frame overwrite the shadow; the last load wins.
- Refresh counter: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances.
  - The digit index wraps from N-1 to 0. On that wrap edge, frame_tick=1 for exactly one cycle.
  - On the same edge, if pending=1, the display register is loaded from the shadow and pending is cleared.
- Load coincident with the wrap edge: the incoming bcd/dp bypass the shadow and commit directly to the display register; pending ends 0.
- Frame sequence: digit 0 slot first, then 1 … N-1.
- Output timing: an/seg/dp_n are registered. They reflect the current digit index one cycle after the index changes.
  - Load-to-display latency is at most N*REFRESH_DIV+1 cycles.
- Digit decode: 0–9 map to standard patterns. Values 10–15 display '-' (seg 7'b0111111).
- Leading-zero blanking (lz_en=1):
  - Scan from digit N-1 downward. A digit is blanked (seg 7'h7F, dp_n 1) while it and all higher digits equal 0 and have dp=0.
  - A nonzero digit, an invalid digit, or a set dp stops blanking from that position down.
  - Digit 0 is never blanked.
  - The anode is still asserted for blanked digits, so timing is uniform.
- lz_en=0: all digits displayed.
- Reset mid-frame: outputs return to reset values immediately and any pending update is discarded.

Optional Feature:
Macro DISP_DIMMING_EN.
- Defined:
  - Adds input bright[3:0] and a free-running 4-bit PWM counter, cleared by reset.
  - The selected anode is asserted only while pwm_cnt <= bright; otherwise all of an is 1.
  - bright=15 gives full on; bright=0 gives a 1/16 duty cycle.
  - seg and dp_n are unaffected.
- Undefined: the port is absent and the anode is always asserted for the selected slot.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - 7-segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - segment bit-order definition
  - active-low polarity constants
- One sub-module, bcd_to_seg7: a combinational 4-bit BCD to 7-bit active-low pattern decoder, with dash for invalid codes. Instantiated once, on the muxed digit.

Test Plan:
All scenarios use N=4, REFRESH_DIV=4.
1. Reset asserted mid-slot with a value displayed -> same cycle an=4'b1111, seg=7'h7F, dp_n=1. After release the first frame shows 0000, with lz_en=1 showing only digit 0 as 7'b1000000.
2. load with bcd=16'h0123, dp=0, lz_en=1 -> after the next frame_tick:
   - digit3: an=4'b0111, seg=7'h7F
   - digit2: seg=7'b1111001
   - digit1: seg=7'b0100100
   - digit0: seg=7'b0110000
3. bcd=16'h00A5, lz_en=1 -> digits 3 and 2 blank, digit1 shows 7'b0111111, digit0 shows 7'b0010010. With lz_en=0, digits 3 and 2 show 7'b1000000.
4. bcd=16'h0012, dp=4'b0100, lz_en=1 -> digit3 blank; digit2 shows '0' with dp_n=0; digit1 shows '1'; digit0 shows '2'.
5. Load 16'h1111 during the digit-1 slot -> slots 2 and 3 still show the old value. New value appears from digit 0 after frame_tick. Two loads in the same frame -> only the second is displayed.
6. Load on the exact wrap cycle -> new value shown in the immediately following digit-0 slot. frame_tick pulses once every 16 cycles.
